// File: rtl/univ_shifter_n.sv
// Universal shift register: logical/rotate/arithmetic shift, parallel load,
// serial-out bit, and a counter-sequenced burst shift with BUSY/DONE handshake.
//
// Ports:
//   clk1   - clock, all state changes on the rising edge
//   Reset  - asynchronous active-low reset
//   IN     - serial fill bit for logical shifts
//   MODE   - 0 = shift right (toward Q[0]), 1 = shift left (toward Q[WIDTH-1])
//   OP     - 00 logical, 01 rotate, 10 arithmetic, 11 parallel load
//   EN     - single-step strobe, acts only when idle
//   D      - parallel load data
//   START  - burst request (priority over EN), shifts CNT positions
//   CNT    - burst length
//   Q      - register contents
//   SOUT   - last bit shifted/rotated out
//   BUSY   - burst shifting in progress
//   DONE   - one-cycle pulse when a burst completes
module univ_shifter_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk1,
    input  logic             Reset,
    input  logic             IN,
    input  logic             MODE,
    input  logic [1:0]       OP,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [CNT_W-1:0] CNT,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [1:0] OP_LSH = 2'b00;
    localparam logic [1:0] OP_ROT = 2'b01;
    localparam logic [1:0] OP_ASH = 2'b10;
    localparam logic [1:0] OP_LD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   rem;
    logic [CNT_W-1:0]   rem_nxt;
    logic [1:0]         lop;
    logic [1:0]         lop_nxt;
    logic               lmode;
    logic               lmode_nxt;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   q_nxt;
    logic               sout;
    logic               sout_nxt;

    // Shared shifter: single steps use the live OP/MODE, a burst uses the
    // copy latched on the START edge so mid-burst changes have no effect.
    logic [1:0]         sh_op;
    logic               sh_mode;
    logic               fill;
    logic [WIDTH-1:0]   sh_q;
    logic               sh_out;

    always_comb begin
        sh_op   = (state == IDLE) ? OP   : lop;
        sh_mode = (state == IDLE) ? MODE : lmode;
    end

    always_comb begin
        fill = IN;
        unique case (1'b1)
            (sh_op == OP_ROT):
                fill = sh_mode ? q[WIDTH-1] : q[0];
            (sh_op == OP_ASH) && !sh_mode:
                fill = q[WIDTH-1];
            (sh_op == OP_ASH) && sh_mode:
                fill = 1'b0;
            default:
                fill = IN;
        endcase
    end

    always_comb begin
        if (sh_mode) begin
            sh_q   = {q[WIDTH-2:0], fill};
            sh_out = q[WIDTH-1];
        end else begin
            sh_q   = {fill, q[WIDTH-1:1]};
            sh_out = q[0];
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        lop_nxt   = lop;
        lmode_nxt = lmode;
        q_nxt     = q;
        sout_nxt  = sout;
        unique case (state)
            IDLE: begin
                if (START) begin
                    // The START edge only arms the burst; shifting begins
                    // on the following edge.
                    lop_nxt   = OP;
                    lmode_nxt = MODE;
                    rem_nxt   = CNT;
                    if ((CNT == '0) || (OP == OP_LD)) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = RUN;
                    end
                end else if (EN) begin
                    if (OP == OP_LD) begin
                        q_nxt = D;
                    end else begin
                        q_nxt    = sh_q;
                        sout_nxt = sh_out;
                    end
                end
            end
            RUN: begin
                q_nxt    = sh_q;
                sout_nxt = sh_out;
                rem_nxt  = rem - 1'b1;
                if (rem == CNT_W'(1)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            rem   <= '0;
            lop   <= OP_LSH;
            lmode <= 1'b0;
            q     <= '0;
            sout  <= 1'b0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            lop   <= lop_nxt;
            lmode <= lmode_nxt;
            q     <= q_nxt;
            sout  <= sout_nxt;
        end
    end

    // BUSY/DONE decode the registered state only.
    assign Q    = q;
    assign SOUT = sout;
    assign BUSY = (state == RUN);
    assign DONE = (state == FIN);

endmodule

// File: tb/tb_univ_shifter_n.sv
// Testbench for univ_shifter_n (WIDTH=8, CNT_W=4).
// Randomised and directed scenarios against an arithmetic reference model.
module tb_univ_shifter_n;

    logic       clk1 = 1'b0;
    logic       Reset;
    logic       IN;
    logic       MODE;
    logic [1:0] OP;
    logic       EN;
    logic [7:0] D;
    logic       START;
    logic [3:0] CNT;
    logic [7:0] Q;
    logic       SOUT;
    logic       BUSY;
    logic       DONE;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mq;
    logic        msout;
    logic [10:0] got;
    logic [10:0] exp_v;

    univ_shifter_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk1  (clk1),
        .Reset (Reset),
        .IN    (IN),
        .MODE  (MODE),
        .OP    (OP),
        .EN    (EN),
        .D     (D),
        .START (START),
        .CNT   (CNT),
        .Q     (Q),
        .SOUT  (SOUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 clk1 = ~clk1;

    // Reference: register value treated as an unsigned integer 0..255.
    function automatic void mshift(input logic [1:0] op, input logic mode,
                                   input logic in_b);
        int unsigned v;
        int unsigned o;
        int unsigned f;
        v = int'(mq);
        if (!mode) begin
            o = v % 2;
            if (op == 2'd0) f = in_b;
            else if (op == 2'd1) f = o;
            else f = v / 128;
            v = v / 2 + f * 128;
        end else begin
            o = v / 128;
            if (op == 2'd0) f = in_b;
            else if (op == 2'd1) f = o;
            else f = 0;
            v = (v * 2) % 256 + f;
        end
        mq    = v[7:0];
        msout = o[0];
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic quiet();
        EN    = 1'b0;
        START = 1'b0;
        IN    = 1'($urandom);
        OP    = 2'($urandom);
        MODE  = 1'($urandom);
        D     = 8'($urandom);
        CNT   = 4'($urandom);
    endtask

    task automatic drive_en(input logic [1:0] op, input logic mode,
                            input logic in_b, input logic [7:0] d);
        EN    = 1'b1;
        START = 1'b0;
        OP    = op;
        MODE  = mode;
        IN    = in_b;
        D     = d;
        tick();
        if (op == 2'd3) mq = d;
        else mshift(op, mode, in_b);
        quiet();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        quiet();
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        drive_en(2'd3, 1'b0, 1'b0, 8'h3C);
        n_cmp++;
        if (Q !== 8'h3C) begin
            n_bad++;
            $display("FAIL rst_preload: got Q=%h want Q=3c", Q);
        end
        #3 Reset = 1'b0;
        #1;
        mq    = 8'h00;
        msout = 1'b0;
        got   = {Q, SOUT, BUSY, DONE};
        n_cmp++;
        if (got !== 11'd0) begin
            n_bad++;
            $display("FAIL rst_async: got Q=%h SOUT=%b BUSY=%b DONE=%b want all 0",
                     Q, SOUT, BUSY, DONE);
        end
        #2 Reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {Q, SOUT, BUSY, DONE};
            n_cmp++;
            if (got !== 11'd0) begin
                n_bad++;
                $display("FAIL rst_idle%0d: got Q=%h SOUT=%b BUSY=%b DONE=%b want all 0",
                         i, Q, SOUT, BUSY, DONE);
            end
        end
    endtask

    task automatic test_load_shift();
        drive_en(2'd3, 1'b0, 1'b0, 8'hA5);
        n_cmp++;
        if ({Q, BUSY, DONE} !== {8'hA5, 2'b00}) begin
            n_bad++;
            $display("FAIL load: got Q=%h BUSY=%b DONE=%b want Q=a5 0 0", Q, BUSY, DONE);
        end
        drive_en(2'd0, 1'b0, 1'b1, 8'h00);
        got = {Q, SOUT, BUSY, DONE};
        n_cmp++;
        if (got !== {8'hD2, 1'b1, 2'b00} || mq !== 8'hD2) begin
            n_bad++;
            $display("FAIL lsr_in1: got Q=%h SOUT=%b want Q=d2 SOUT=1", Q, SOUT);
        end
        drive_en(2'd3, 1'b0, 1'b0, 8'hA5);
        drive_en(2'd0, 1'b1, 1'b0, 8'h00);
        got = {Q, SOUT, BUSY, DONE};
        n_cmp++;
        if (got !== {8'h4A, 1'b1, 2'b00}) begin
            n_bad++;
            $display("FAIL lsl_in0: got Q=%h SOUT=%b want Q=4a SOUT=1", Q, SOUT);
        end
        for (int i = 0; i < 3; i++) begin
            quiet();
            tick();
            got = {Q, SOUT, BUSY, DONE};
            n_cmp++;
            if (got !== {8'h4A, 1'b1, 2'b00}) begin
                n_bad++;
                $display("FAIL hold%0d: got Q=%h SOUT=%b want Q=4a SOUT=1", i, Q, SOUT);
            end
        end
    endtask

    // One burst from idle; with noise set, START/EN/OP/MODE/D/CNT are
    // scrambled during the burst and the completion cycle.
    task automatic test_burst(input logic [1:0] op, input logic mode,
                              input logic [3:0] cnt, input bit noise,
                              input string tag);
        bit   run;
        logic in_v;
        START = 1'b1;
        EN    = 1'($urandom);
        OP    = op;
        MODE  = mode;
        CNT   = cnt;
        D     = 8'($urandom);
        IN    = 1'($urandom);
        tick();
        run   = (cnt != 4'd0) && (op != 2'd3);
        exp_v = {mq, msout, run, !run};
        got   = {Q, SOUT, BUSY, DONE};
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s start: got Q=%h SOUT=%b BUSY=%b DONE=%b want Q=%h SOUT=%b BUSY=%b DONE=%b",
                     tag, Q, SOUT, BUSY, DONE, exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
        end
        if (run) begin
            for (int i = 1; i <= int'(cnt); i++) begin
                if (noise) begin
                    START = 1'($urandom);
                    EN    = 1'($urandom);
                    OP    = 2'($urandom);
                    MODE  = 1'($urandom);
                    D     = 8'($urandom);
                    CNT   = 4'($urandom);
                end else begin
                    START = 1'b0;
                    EN    = 1'b0;
                end
                IN   = 1'($urandom);
                in_v = IN;
                tick();
                mshift(op, mode, in_v);
                exp_v = {mq, msout, i < int'(cnt), i == int'(cnt)};
                got   = {Q, SOUT, BUSY, DONE};
                n_cmp++;
                if (got !== exp_v) begin
                    n_bad++;
                    $display("FAIL %s shift%0d: got Q=%h SOUT=%b BUSY=%b DONE=%b want Q=%h SOUT=%b BUSY=%b DONE=%b",
                             tag, i, Q, SOUT, BUSY, DONE,
                             exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
        if (noise) begin
            START = 1'b1;
            EN    = 1'b1;
            OP    = 2'($urandom);
            D     = 8'($urandom);
        end else begin
            START = 1'b0;
            EN    = 1'b0;
        end
        tick();
        exp_v = {mq, msout, 2'b00};
        got   = {Q, SOUT, BUSY, DONE};
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s fin: got Q=%h SOUT=%b BUSY=%b DONE=%b want Q=%h SOUT=%b BUSY=0 DONE=0",
                     tag, Q, SOUT, BUSY, DONE, exp_v[10:3], exp_v[2]);
        end
        quiet();
    endtask

    task automatic test_bursts();
        drive_en(2'd3, 1'b0, 1'b0, 8'hA5);
        test_burst(2'd1, 1'b1, 4'd3, 1'b1, "rotl3");
        n_cmp++;
        if ({Q, SOUT} !== {8'h2D, 1'b1}) begin
            n_bad++;
            $display("FAIL rotl3_end: got Q=%h SOUT=%b want Q=2d SOUT=1", Q, SOUT);
        end
        drive_en(2'd3, 1'b0, 1'b0, 8'h96);
        test_burst(2'd2, 1'b0, 4'd2, 1'b0, "asr2");
        n_cmp++;
        if ({Q, SOUT} !== {8'hE5, 1'b1}) begin
            n_bad++;
            $display("FAIL asr2_end: got Q=%h SOUT=%b want Q=e5 SOUT=1", Q, SOUT);
        end
        test_burst(2'($urandom), 1'($urandom), 4'd0, 1'b1, "cnt0");
        test_burst(2'd3, 1'b0, 4'd5, 1'b1, "ldburst");
        test_burst(2'd0, 1'b1, 4'd15, 1'b1, "flush15");
        test_burst(2'd1, 1'b0, 4'd11, 1'b1, "rotr11");
    endtask

    task automatic test_mid_reset();
        drive_en(2'd3, 1'b0, 1'b0, 8'h5A);
        START = 1'b1;
        OP    = 2'd0;
        MODE  = 1'b0;
        CNT   = 4'd5;
        tick();
        START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            IN = 1'($urandom);
            tick();
        end
        n_cmp++;
        if (BUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_busy: got BUSY=%b want BUSY=1", BUSY);
        end
        #2 Reset = 1'b0;
        #1;
        mq    = 8'h00;
        msout = 1'b0;
        got   = {Q, SOUT, BUSY, DONE};
        n_cmp++;
        if (got !== 11'd0) begin
            n_bad++;
            $display("FAIL midrst_async: got Q=%h SOUT=%b BUSY=%b DONE=%b want all 0",
                     Q, SOUT, BUSY, DONE);
        end
        tick();
        #2 Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            got = {Q, SOUT, BUSY, DONE};
            n_cmp++;
            if (got !== 11'd0) begin
                n_bad++;
                $display("FAIL midrst_nodone%0d: got Q=%h SOUT=%b BUSY=%b DONE=%b want all 0",
                         i, Q, SOUT, BUSY, DONE);
            end
        end
        drive_en(2'd0, 1'b1, 1'b1, 8'h00);
        got = {Q, SOUT, BUSY, DONE};
        n_cmp++;
        if (got !== {8'h01, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL midrst_step: got Q=%h SOUT=%b want Q=01 SOUT=0", Q, SOUT);
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic       mode;
        logic       in_b;
        logic [7:0] d;
        for (int k = 0; k < 60; k++) begin
            op   = 2'($urandom);
            mode = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                test_burst(op, mode, 4'($urandom), 1'b1, "rnd_burst");
            end else begin
                in_b = 1'($urandom);
                d    = 8'($urandom);
                drive_en(op, mode, in_b, d);
                exp_v = {mq, msout, 2'b00};
                got   = {Q, SOUT, BUSY, DONE};
                n_cmp++;
                if (got !== exp_v) begin
                    n_bad++;
                    $display("FAIL rnd_step%0d op=%0d mode=%0d: got Q=%h SOUT=%b BUSY=%b DONE=%b want Q=%h SOUT=%b",
                             k, op, mode, Q, SOUT, BUSY, DONE, exp_v[10:3], exp_v[2]);
                end
            end
        end
    endtask

    initial begin
        mq    = 8'h00;
        msout = 1'b0;
        Reset = 1'b0;
        quiet();
        test_reset();
        test_load_shift();
        test_bursts();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
